// File: rtl/clock_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the clock/reset bring-up sequencer.
package clock_reset_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_SAT_W   = 8;

  function automatic int max_cycles(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/clock_reset_sequencer_lock_synchroniser.sv
// Multi-flop synchroniser bringing the raw PLL lock into the system clock domain.
module lock_synchroniser
  import clock_reset_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_raw,
  output logic lock_sync
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk) begin
    if (rst) sync_p <= '0;
    else     sync_p <= {sync_p[STAGES-2:0], lock_raw};
  end

  assign lock_sync = sync_p[STAGES-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// PLL reset / lock qualification and staggered release of downstream reset channels.
module clock_reset_sequencer
  import clock_reset_pkg::*;
#(
  parameter int NUM_CH              = 4,
  parameter int PLL_RST_CYCLES      = 48,
  parameter int LOCK_TIMEOUT_CYCLES = 480000,
  parameter int LOCK_STABLE_CYCLES  = 4800,
  parameter int CH_SPACING_CYCLES   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pll_locked_i,
  input  logic                 restart_i,
  output logic                 pll_rst_o,
  output logic [NUM_CH-1:0]    ch_rst_o,
  output logic                 ready_o,
  output logic [CNT_SAT_W-1:0] lock_loss_cnt_o,
  output logic [CNT_SAT_W-1:0] timeout_cnt_o
);

  localparam int TIMER_W = $clog2(max_cycles(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                             LOCK_STABLE_CYCLES, CH_SPACING_CYCLES)) + 1;
  localparam int IDX_W   = $clog2(NUM_CH + 1);

  localparam logic [TIMER_W-1:0] RST_LAST = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STB_LAST = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SPC_LAST = TIMER_W'(CH_SPACING_CYCLES - 1);

  state_t               state, state_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [IDX_W-1:0]     ch_idx, ch_idx_n;
  logic [NUM_CH-1:0]    ch_rst_n;
  logic [CNT_SAT_W-1:0] loss_cnt_n, tmo_cnt_n;
  logic                 lock_s;

  function automatic logic [CNT_SAT_W-1:0] sat_inc(input logic [CNT_SAT_W-1:0] v);
    return (&v) ? v : v + CNT_SAT_W'(1);
  endfunction

  lock_synchroniser #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk      (clk_i),
    .rst      (rst_i),
    .lock_raw (pll_locked_i),
    .lock_sync(lock_s)
  );

  // Restart outranks lock loss and timeout; nothing interrupts the PLL reset hold.
  always_comb begin
    state_n    = state;
    timer_n    = timer + TIMER_W'(1);
    ch_idx_n   = ch_idx;
    ch_rst_n   = ch_rst_o;
    loss_cnt_n = lock_loss_cnt_o;
    tmo_cnt_n  = timeout_cnt_o;

    if (restart_i && state != PLL_RST) begin
      state_n  = PLL_RST;
      timer_n  = '0;
      ch_rst_n = '1;
    end else begin
      case (state)
        PLL_RST: begin
          if (timer == RST_LAST) begin
            state_n = WAIT_LOCK;
            timer_n = '0;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_n = STABLE;
            timer_n = '0;
          end else if (timer == TMO_LAST) begin
            state_n   = PLL_RST;
            timer_n   = '0;
            tmo_cnt_n = sat_inc(timeout_cnt_o);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_n = WAIT_LOCK;
            timer_n = '0;
          end else if (timer == STB_LAST) begin
            state_n     = RELEASE;
            timer_n     = '0;
            ch_idx_n    = IDX_W'(1);
            ch_rst_n    = '1;
            ch_rst_n[0] = 1'b0;
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            state_n    = PLL_RST;
            timer_n    = '0;
            ch_rst_n   = '1;
            loss_cnt_n = sat_inc(lock_loss_cnt_o);
          end else if (timer == SPC_LAST) begin
            timer_n = '0;
            if (ch_idx == IDX_W'(NUM_CH)) begin
              state_n = RUN;
            end else begin
              for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == IDX_W'(i)) ch_rst_n[i] = 1'b0;
              end
              ch_idx_n = ch_idx + IDX_W'(1);
            end
          end
        end
        RUN: begin
          timer_n = timer;
          if (!lock_s) begin
            state_n    = PLL_RST;
            timer_n    = '0;
            ch_rst_n   = '1;
            loss_cnt_n = sat_inc(lock_loss_cnt_o);
          end
        end
        default: begin
          state_n  = PLL_RST;
          timer_n  = '0;
          ch_rst_n = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= PLL_RST;
      timer           <= '0;
      ch_idx          <= '0;
      pll_rst_o       <= 1'b1;
      ch_rst_o        <= '1;
      ready_o         <= 1'b0;
      lock_loss_cnt_o <= '0;
      timeout_cnt_o   <= '0;
    end else begin
      state           <= state_n;
      timer           <= timer_n;
      ch_idx          <= ch_idx_n;
      pll_rst_o       <= (state_n == PLL_RST);
      ch_rst_o        <= ch_rst_n;
      ready_o         <= (state_n == RUN);
      lock_loss_cnt_o <= loss_cnt_n;
      timeout_cnt_o   <= tmo_cnt_n;
    end
  end

endmodule
